bus_arbiter: RTL and testbench

//  Two-master arbiter for the shared 8-bit system bus. Sequences ownership between

---
 rtl/bus_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter for the shared 8-bit system bus.
// Hands bus ownership to master 0 or master 1 and drives m_sel to the bus
// address/data muxes. An owner keeps the bus for as long as it requests. If the
// other master is waiting, the owner is preempted after MAX_HOLD cycles.
// Ports:
//   clk       in   bus clock, rising edge
//   reset     in   synchronous, active-high reset
//   m0_req    in   master 0 bus request (level)
//   m1_req    in   master 1 bus request (level)
//   m0_grant  out  master 0 owns the bus (registered)
//   m1_grant  out  master 1 owns the bus (registered)
//   m_sel     out  bus mux select, 0 = M0, 1 = M1; keeps the last owner when idle
//   bus_busy  out  m0_grant | m1_grant (registered)
//   preempt   out  1-cycle pulse when a holder is forcibly switched out
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned RR_EN    = 1,
    parameter int unsigned CNT_W    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_grant,
    output logic m1_grant,
    output logic m_sel,
    output logic bus_busy,
    output logic preempt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // MAX_HOLD == 0 disables preemption, so the limit value is unused in that case.
    localparam bit              HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam bit              RR_ON    = (RR_EN != 0);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic             last;
    logic             last_nxt;
    logic             sel_nxt;
    logic             pre_nxt;

    // Next-state, hold counter and registered-output precompute.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last;
        sel_nxt   = m_sel;
        pre_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    // Round-robin favours the master that did not own the bus last.
                    state_nxt = (RR_ON && !last) ? GNT1 : GNT0;
                end else if (m0_req) begin
                    state_nxt = GNT0;
                end else if (m1_req) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_req) begin
                    state_nxt = m1_req ? GNT1 : IDLE;
                end else if (m1_req && HOLD_EN) begin
                    if (hold_cnt == HOLD_LIM) begin
                        state_nxt = GNT1;
                        pre_nxt   = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + CNT_W'(1);
                    end
                end
            end
            GNT1: begin
                if (!m1_req) begin
                    state_nxt = m0_req ? GNT0 : IDLE;
                end else if (m0_req && HOLD_EN) begin
                    if (hold_cnt == HOLD_LIM) begin
                        state_nxt = GNT0;
                        pre_nxt   = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Any ownership change restarts the hold window and records the new owner.
        if (state_nxt != state) begin
            hold_nxt = '0;
            if (state_nxt == GNT0) begin
                last_nxt = 1'b0;
                sel_nxt  = 1'b0;
            end else if (state_nxt == GNT1) begin
                last_nxt = 1'b1;
                sel_nxt  = 1'b1;
            end
        end
    end

    // State and output registers; outputs are loaded from next-state so they align with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last     <= 1'b1;
            m0_grant <= 1'b0;
            m1_grant <= 1'b0;
            m_sel    <= 1'b0;
            bus_busy <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
            m0_grant <= (state_nxt == GNT0);
            m1_grant <= (state_nxt == GNT1);
            m_sel    <= sel_nxt;
            bus_busy <= (state_nxt != IDLE);
            preempt  <= pre_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: bench for bus_arbiter. Three instances share clk/reset/req:
//   inst 0: MAX_HOLD=16, round-robin
//   inst 1: MAX_HOLD=16, fixed priority
//   inst 2: MAX_HOLD=1,  round-robin
// Each instance is tracked by an ownership-level reference model.
module tb_bus_arbiter;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic m0_req = 1'b0;
    logic m1_req = 1'b0;

    logic [2:0] g0;
    logic [2:0] g1;
    logic [2:0] sel;
    logic [2:0] busy;
    logic [2:0] pre;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_HOLD(16), .RR_EN(1), .CNT_W(5)) u_rr (
        .clk(clk), .reset(reset), .m0_req(m0_req), .m1_req(m1_req),
        .m0_grant(g0[0]), .m1_grant(g1[0]), .m_sel(sel[0]), .bus_busy(busy[0]), .preempt(pre[0]));
    bus_arbiter #(.MAX_HOLD(16), .RR_EN(0), .CNT_W(5)) u_fp (
        .clk(clk), .reset(reset), .m0_req(m0_req), .m1_req(m1_req),
        .m0_grant(g0[1]), .m1_grant(g1[1]), .m_sel(sel[1]), .bus_busy(busy[1]), .preempt(pre[1]));
    bus_arbiter #(.MAX_HOLD(1), .RR_EN(1), .CNT_W(5)) u_mh1 (
        .clk(clk), .reset(reset), .m0_req(m0_req), .m1_req(m1_req),
        .m0_grant(g0[2]), .m1_grant(g1[2]), .m_sel(sel[2]), .bus_busy(busy[2]), .preempt(pre[2]));

    int checks   = 0;
    int failures = 0;

    int mh[3] = '{16, 16, 1};
    bit rr[3] = '{1'b1, 1'b0, 1'b1};

    // Model state: owner (-1 = nobody), cycles the other master has waited on the owner.
    int owner[3];
    int waitc[3];
    bit last_m[3];
    bit sel_m[3];
    bit pre_m[3];

    function automatic void model_update(input int i, input bit rst, input bit r0, input bit r1);
        bit rq[2];
        int nxt;
        rq[0] = r0;
        rq[1] = r1;
        if (rst) begin
            owner[i]  = -1;
            waitc[i]  = 0;
            last_m[i] = 1'b1;
            sel_m[i]  = 1'b0;
            pre_m[i]  = 1'b0;
            return;
        end
        pre_m[i] = 1'b0;
        nxt = owner[i];
        if (owner[i] < 0) begin
            if (r0 && r1) nxt = (rr[i] && last_m[i] == 1'b0) ? 1 : 0;
            else if (r0) nxt = 0;
            else if (r1) nxt = 1;
            else nxt = -1;
        end else begin
            int o;
            int p;
            o = owner[i];
            p = 1 - o;
            if (!rq[o]) begin
                nxt = rq[p] ? p : -1;
            end else if (rq[p]) begin
                waitc[i] = waitc[i] + 1;
                if (mh[i] != 0 && waitc[i] >= mh[i]) begin
                    nxt      = p;
                    pre_m[i] = 1'b1;
                end
            end
        end
        if (nxt != owner[i]) begin
            waitc[i] = 0;
            if (nxt >= 0) begin
                last_m[i] = (nxt == 1);
                sel_m[i]  = (nxt == 1);
            end
        end
        owner[i] = nxt;
    endfunction

    function automatic logic [4:0] dut_vec(input int i);
        return {g0[i], g1[i], sel[i], busy[i], pre[i]};
    endfunction

    function automatic logic [4:0] exp_vec(input int i);
        return {owner[i] == 0, owner[i] == 1, sel_m[i], owner[i] >= 0, pre_m[i]};
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, settle past the edge.
    task automatic step(input bit rst, input bit r0, input bit r1);
        reset  = rst;
        m0_req = r0;
        m1_req = r1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_update(i, rst, r0, r1);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_vec(i) !== 5'b00000) begin
                failures++;
                $display("FAIL reset_state inst=%0d got g0,g1,sel,busy,pre=%b want=00000", i, dut_vec(i));
            end
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_vec(0) !== 5'b01110) begin
            failures++;
            $display("FAIL reset_pre_gnt1 got=%b want=01110", dut_vec(0));
        end
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_vec(i) !== 5'b00000) begin
                failures++;
                $display("FAIL reset_mid_gnt1 inst=%0d got=%b want=00000", i, dut_vec(i));
            end
        end
    endtask

    task automatic test_single_m1();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (dut_vec(0) !== 5'b01110) begin
                failures++;
                $display("FAIL single_m1 cycle=%0d got=%b want=01110", k, dut_vec(0));
            end
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec(0) !== 5'b00100) begin
            failures++;
            $display("FAIL single_m1_release got=%b want=00100", dut_vec(0));
        end
    endtask

    task automatic test_rr_tie();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if ({dut_vec(0), dut_vec(1)} !== {5'b10010, 5'b10010}) begin
            failures++;
            $display("FAIL tie_first rr=%b fp=%b want rr=10010 fp=10010", dut_vec(0), dut_vec(1));
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if ({dut_vec(0), dut_vec(1)} !== {5'b01110, 5'b10010}) begin
            failures++;
            $display("FAIL tie_second rr=%b fp=%b want rr=01110 fp=10010", dut_vec(0), dut_vec(1));
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                failures++;
                $display("FAIL tie_model inst=%0d got=%b want=%b", i, dut_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_preempt();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b1, 1'b1);
            if (k < 16) begin
                checks++;
                if ({dut_vec(0), dut_vec(1)} !== {5'b10010, 5'b10010}) begin
                    failures++;
                    $display("FAIL preempt_hold k=%0d rr=%b fp=%b want 10010", k, dut_vec(0), dut_vec(1));
                end
            end else begin
                checks++;
                if ({dut_vec(0), dut_vec(1)} !== {5'b01111, 5'b01111}) begin
                    failures++;
                    $display("FAIL preempt_switch rr=%b fp=%b want 01111", dut_vec(0), dut_vec(1));
                end
            end
        end
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if ({dut_vec(0), dut_vec(1)} !== {5'b01110, 5'b01110}) begin
            failures++;
            $display("FAIL preempt_pulse_end rr=%b fp=%b want 01110", dut_vec(0), dut_vec(1));
        end
    endtask

    task automatic test_handover();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (dut_vec(0) !== 5'b10010) begin
            failures++;
            $display("FAIL handover_before got=%b want=10010", dut_vec(0));
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_vec(0) !== 5'b01110) begin
            failures++;
            $display("FAIL handover_edge got=%b want=01110", dut_vec(0));
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                failures++;
                $display("FAIL handover_model inst=%0d got=%b want=%b", i, dut_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_random();
        bit r0;
        bit r1;
        int w[3][2];
        r0 = 1'b0;
        r1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w[i][0] = 0;
            w[i][1] = 0;
        end
        step(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 10000; n++) begin
            // Alternate between busy-toggling and long-hold phases to reach preemption.
            int span;
            span = ((n / 1000) % 2 == 1) ? 40 : 6;
            if ($urandom_range(span, 0) == 0) r0 = ~r0;
            if ($urandom_range(span, 0) == 0) r1 = ~r1;
            step(1'b0, r0, r1);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL rand_model n=%0d inst=%0d got=%b want=%b", n, i, dut_vec(i), exp_vec(i));
                end
                checks++;
                if ((g0[i] & g1[i]) !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_exclusive n=%0d inst=%0d got g0=%b g1=%b want not both 1", n, i, g0[i], g1[i]);
                end
                checks++;
                if ((g0[i] && !r0) || (g1[i] && !r1)) begin
                    failures++;
                    $display("FAIL rand_grant_no_req n=%0d inst=%0d got g0=%b g1=%b req=%b%b", n, i, g0[i], g1[i], r0, r1);
                end
                for (int m = 0; m < 2; m++) begin
                    bit rq;
                    logic gm;
                    rq = (m == 1) ? r1 : r0;
                    gm = (m == 1) ? g1[i] : g0[i];
                    if (rq && gm !== 1'b1) w[i][m] = w[i][m] + 1;
                    else w[i][m] = 0;
                    checks++;
                    if (w[i][m] > mh[i] + 1) begin
                        failures++;
                        $display("FAIL rand_wait n=%0d inst=%0d master=%0d got wait=%0d want<=%0d", n, i, m, w[i][m], mh[i] + 1);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) model_update(i, 1'b1, 1'b0, 1'b0);
        test_reset();
        test_single_m1();
        test_rr_tie();
        test_preempt();
        test_handover();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
